// File: rtl/paddle_key_scheduler.sv
// Per-frame paddle command scheduler: snapshots the keycode word, scans it, resolves directions and offers one step command per frame.
// Optional hold-based acceleration is compiled in with `define PADDLE_KEY_SCHED_ACCEL_EN.
module paddle_key_scheduler #(
  parameter int unsigned SLOTS        = 4,
  parameter logic [7:0]  P1_UP        = 8'h1A,
  parameter logic [7:0]  P1_DN        = 8'h16,
  parameter logic [7:0]  P2_UP        = 8'h52,
  parameter logic [7:0]  P2_DN        = 8'h51,
  parameter int unsigned BASE_SPEED   = 1,
  parameter int unsigned MAX_SPEED    = 4,
  parameter int unsigned ACCEL_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8*SLOTS-1:0] keycode,
  input  logic               frame_tick,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [3:0]         p1_step,
  output logic [3:0]         p2_step,
  output logic               busy,
  output logic [7:0]         overrun_cnt
);

  localparam int unsigned IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned MAG_W  = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, OFFER} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  // Parameter sanity checks at elaboration
  if (SLOTS == 0) begin : g_bad_slots
    $error("SLOTS must be at least 1");
  end
  if (BASE_SPEED < 1 || BASE_SPEED > 7) begin : g_bad_base
    $error("BASE_SPEED must be in 1..7");
  end
  if (MAX_SPEED < BASE_SPEED || MAX_SPEED > 7) begin : g_bad_max
    $error("MAX_SPEED must be in BASE_SPEED..7");
  end
  if (ACCEL_FRAMES == 0) begin : g_bad_accel
    $error("ACCEL_FRAMES must be non-zero");
  end

  state_t                     state;
  state_t                     nxt;
  logic [SLOTS-1:0][7:0]      snapshot;
  logic [IDX_W-1:0]           idx;
  logic                       p1u, p1d, p2u, p2d;
  logic [7:0]                 cur_slot;
  logic                       hit_p1u, hit_p1d, hit_p2u, hit_p2d;
  logic                       last_idx;
  logic                       cmd_valid_d;
  logic                       busy_d;
  dir_t                       p1_dir, p2_dir;
  logic [MAG_W-1:0]           p1_mag, p2_mag;
  logic [STEP_W-1:0]          p1_step_d, p2_step_d;

  function automatic dir_t dir_of(input logic up, input logic dn);
    dir_t d;
    d = DIR_NONE;
    if (up && !dn) d = DIR_UP;
    else if (dn && !up) d = DIR_DN;
    return d;
  endfunction

  function automatic logic [STEP_W-1:0] signed_step(input dir_t d, input logic [MAG_W-1:0] mag);
    logic [STEP_W-1:0] s;
    s = '0;
    case (d)
      DIR_UP:  s = STEP_W'(0) - STEP_W'(mag);
      DIR_DN:  s = STEP_W'(mag);
      default: s = '0;
    endcase
    return s;
  endfunction

  // Slot matcher; a zero slot is an empty key position
  assign cur_slot = snapshot[idx];
  assign hit_p1u  = (cur_slot != 8'h00) && (cur_slot == P1_UP);
  assign hit_p1d  = (cur_slot != 8'h00) && (cur_slot == P1_DN);
  assign hit_p2u  = (cur_slot != 8'h00) && (cur_slot == P2_UP);
  assign hit_p2d  = (cur_slot != 8'h00) && (cur_slot == P2_DN);
  assign last_idx = (idx == IDX_W'(SLOTS - 1));

  assign p1_dir = dir_of(p1u, p1d);
  assign p2_dir = dir_of(p2u, p2d);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (frame_tick) nxt = SCAN;
      SCAN:    if (last_idx) nxt = RESOLVE;
      RESOLVE: nxt = OFFER;
      OFFER:   if (cmd_valid && cmd_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output logic: cmd_valid follows OFFER one cycle later and drops on the transfer edge
  always_comb begin
    cmd_valid_d = 1'b0;
    busy_d      = 1'b0;
    cmd_valid_d = (state == OFFER) && !(cmd_valid && cmd_ready);
    busy_d      = (nxt != IDLE);
  end

`ifdef PADDLE_KEY_SCHED_ACCEL_EN
  dir_t             p1_last, p2_last;
  logic [CNT_W-1:0] p1_hold, p2_hold;
  logic [CNT_W-1:0] p1_hold_d, p2_hold_d;

  function automatic logic [CNT_W-1:0] hold_next(input dir_t d, input dir_t last,
                                                 input logic [CNT_W-1:0] h);
    logic [CNT_W-1:0] n;
    n = '0;
    if (d != DIR_NONE && d == last) n = (h == {CNT_W{1'b1}}) ? h : h + CNT_W'(1);
    return n;
  endfunction

  function automatic logic [MAG_W-1:0] mag_of(input logic [CNT_W-1:0] h);
    int unsigned m;
    m = BASE_SPEED + 32'(h) / ACCEL_FRAMES;
    if (m > MAX_SPEED) m = MAX_SPEED;
    return MAG_W'(m);
  endfunction

  assign p1_hold_d = hold_next(p1_dir, p1_last, p1_hold);
  assign p2_hold_d = hold_next(p2_dir, p2_last, p2_hold);
  assign p1_mag    = mag_of(p1_hold_d);
  assign p2_mag    = mag_of(p2_hold_d);

  // Hold counters advance only on resolved frames
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_hold <= '0;
      p2_hold <= '0;
      p1_last <= DIR_NONE;
      p2_last <= DIR_NONE;
    end else if (state == RESOLVE) begin
      p1_hold <= p1_hold_d;
      p2_hold <= p2_hold_d;
      p1_last <= p1_dir;
      p2_last <= p2_dir;
    end
  end
`else
  assign p1_mag = MAG_W'(BASE_SPEED);
  assign p2_mag = MAG_W'(BASE_SPEED);
`endif

  assign p1_step_d = signed_step(p1_dir, p1_mag);
  assign p2_step_d = signed_step(p2_dir, p2_mag);

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapshot    <= '0;
      idx         <= '0;
      p1u         <= 1'b0;
      p1d         <= 1'b0;
      p2u         <= 1'b0;
      p2d         <= 1'b0;
      p1_step     <= '0;
      p2_step     <= '0;
      cmd_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      cmd_valid <= cmd_valid_d;
      busy      <= busy_d;
      if (frame_tick && state != IDLE && overrun_cnt != {CNT_W{1'b1}})
        overrun_cnt <= overrun_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (frame_tick) begin
            snapshot <= keycode;
            idx      <= '0;
            p1u      <= 1'b0;
            p1d      <= 1'b0;
            p2u      <= 1'b0;
            p2d      <= 1'b0;
          end
        end
        SCAN: begin
          p1u <= p1u | hit_p1u;
          p1d <= p1d | hit_p1d;
          p2u <= p2u | hit_p2u;
          p2d <= p2d | hit_p2d;
          idx <= idx + IDX_W'(1);
        end
        RESOLVE: begin
          p1_step <= p1_step_d;
          p2_step <= p2_step_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_key_scheduler.sv
// Directed and randomized bench for paddle_key_scheduler against a frame-level reference model.
// Follows the accelerated behaviour when PADDLE_KEY_SCHED_ACCEL_EN is defined.
module tb_paddle_key_scheduler;

  localparam int unsigned SLOTS = 4;
  localparam logic [7:0]  P1_UP = 8'h1A;
  localparam logic [7:0]  P1_DN = 8'h16;
  localparam logic [7:0]  P2_UP = 8'h52;
  localparam logic [7:0]  P2_DN = 8'h51;
  localparam int          BASE  = 1;
  localparam int          MAXS  = 4;
  localparam int          AF    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] keycode;
  logic        frame_tick;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [3:0]  p1_step;
  logic [3:0]  p2_step;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int errors = 0;
  int hold_m[2];
  int last_m[2];

  always #5 clk = ~clk;

  paddle_key_scheduler dut (
    .clk(clk), .reset(reset), .keycode(keycode), .frame_tick(frame_tick),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .p1_step(p1_step), .p2_step(p2_step),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: direction 0=none 1=up 2=down; hold counts consecutive resolved frames
  function automatic logic [3:0] model_player(input int p, input bit up, input bit dn);
    int dir, mag, s;
    dir = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
`ifdef PADDLE_KEY_SCHED_ACCEL_EN
    if (dir == 0) hold_m[p] = 0;
    else if (dir == last_m[p]) hold_m[p] = (hold_m[p] >= 255) ? 255 : hold_m[p] + 1;
    else hold_m[p] = 0;
    last_m[p] = dir;
    mag = BASE + hold_m[p] / AF;
    if (mag > MAXS) mag = MAXS;
`else
    mag = BASE;
`endif
    s = (dir == 0) ? 0 : ((dir == 1) ? -mag : mag);
    return 4'(s);
  endfunction

  task automatic model_frame(input logic [31:0] kc, output logic [3:0] e1, output logic [3:0] e2);
    bit f1u, f1d, f2u, f2d;
    logic [7:0] b;
    f1u = 0; f1d = 0; f2u = 0; f2d = 0;
    for (int i = 0; i < SLOTS; i++) begin
      b = kc[8*i +: 8];
      if (b == P1_UP) f1u = 1;
      if (b == P1_DN) f1d = 1;
      if (b == P2_UP) f2u = 1;
      if (b == P2_DN) f2d = 1;
    end
    e1 = model_player(0, f1u, f1d);
    e2 = model_player(1, f2u, f2d);
  endtask

  function automatic logic [31:0] rand_kc();
    logic [31:0] kc;
    logic [7:0]  b;
    kc = '0;
    for (int i = 0; i < SLOTS; i++) begin
      case ($urandom_range(0, 7))
        0: b = P1_UP;
        1: b = P1_DN;
        2: b = P2_UP;
        3: b = P2_DN;
        4: b = 8'h00;
        default: b = 8'($urandom);
      endcase
      kc[8*i +: 8] = b;
    end
    return kc;
  endfunction

  // One frame with cmd_ready high; keycode optionally changes change_at cycles after the tick
  task automatic do_frame(input logic [31:0] kc, input int change_at, input logic [31:0] kc2);
    logic [3:0] e1, e2;
    int n;
    bit got;
    model_frame(kc, e1, e2);
    keycode = kc;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 0;
    got = 0;
    while (n < 20 && !got) begin
      if (change_at != 0 && n == change_at) keycode = kc2;
      step();
      n++;
      got = cmd_valid;
    end
    check("latency", 32'(n), 32'd6);
    check("p1_step", 32'(p1_step), 32'(e1));
    check("p2_step", 32'(p2_step), 32'(e2));
    check("busy_offer", 32'(busy), 32'd1);
    step();
    check("valid_drop", 32'(cmd_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] kc;
    logic [3:0]  s1, s2;
    int          n;

    hold_m = '{0, 0};
    last_m = '{0, 0};
    reset = 1'b1;
    keycode = '0;
    frame_tick = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p1", 32'(p1_step), 32'd0);
    check("rst_p2", 32'(p2_step), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    reset = 1'b0;
    step();

    do_frame(32'h0000_001A, 0, 0);
    do_frame(32'h0051_1A16, 0, 0);

    // Long hold of P2 up in slot 3, then release and re-press
    repeat (30) do_frame(32'h5200_0000, 0, 0);
    do_frame(32'h0000_0000, 0, 0);
    do_frame(32'h5200_0000, 0, 0);

    repeat (40) do_frame(rand_kc(), int'($urandom_range(0, 4)), rand_kc());

    // Keycode change mid-scan must not affect the command
    do_frame(32'h0000_0016, 2, 32'h0000_001A);

    // Stalled OFFER with two ignored ticks
    kc = rand_kc();
    model_frame(kc, s1, s2);
    cmd_ready = 1'b0;
    keycode = kc;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n = 0;
    while (n < 20 && !cmd_valid) begin
      step();
      n++;
    end
    check("stall_latency", 32'(n), 32'd6);
    for (int i = 0; i < 20; i++) begin
      keycode = $urandom;
      if (i == 5 || i == 12) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("stall_valid", 32'(cmd_valid), 32'd1);
      check("stall_p1", 32'(p1_step), 32'(s1));
      check("stall_p2", 32'(p2_step), 32'(s2));
    end
    check("overrun", 32'(overrun_cnt), 32'd2);
    cmd_ready = 1'b1;
    step();
    check("stall_release", 32'(cmd_valid), 32'd0);
    check("stall_busy", 32'(busy), 32'd0);
    step();
    check("single_transfer", 32'(cmd_valid), 32'd0);
    check("hold_p1_after", 32'(p1_step), 32'(s1));
    do_frame(rand_kc(), 0, 0);

    // Reset asserted during SCAN
    repeat (10) do_frame(32'h0000_001A, 0, 0);
    keycode = 32'h0000_001A;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    step();
    check("scan_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(cmd_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_p1", 32'(p1_step), 32'd0);
    check("arst_p2", 32'(p2_step), 32'd0);
    check("arst_overrun", 32'(overrun_cnt), 32'd0);
    hold_m = '{0, 0};
    last_m = '{0, 0};
    step();
    reset = 1'b0;
    step();
    check("post_rst_valid", 32'(cmd_valid), 32'd0);
    do_frame(32'h0000_001A, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
